tv80_bus_seq: RTL

Parametrised negative-edge bus-strobe sequencer for the TV80 core. It takes the core's one-hot machine-cycle and T-state vectors plus cycle qualifiers and produces the external mreq_n/iorq_n/rd_n/wr_n strobes. It inserts a programmable number of automatic wait states per cycle type, drives refresh mreq_n during M1, and latches read data. It is the generalised successor to the fixed negedge wrapper, and it sits between tv80_core and the SoC memory/IO decode.

---
 rtl/tv80_bus_seq_if.sv | 35 +++
 rtl/tv80_bus_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tv80_bus_seq_if.sv
// Bus bundle between the TV80 core side and the negedge strobe sequencer.
// Carries the clock enable, the core's cycle/T-state qualifiers and read data
// inward, and the external strobes, wait-to-core, latched data and the wait
// counter outward.
//   master : core/SoC side (drives qualifiers, samples strobes)
//   slave  : sequencer side (samples qualifiers, drives strobes)
interface tv80_bus_seq_if;
   logic       cen;
   logic [6:0] mcycle;
   logic [6:0] tstate;
   logic       intcycle_n;
   logic       iorq;
   logic       no_read;
   logic       write;
   logic       rfsh_n;
   logic       ext_wait_n;
   logic [7:0] di;
   logic       mreq_n;
   logic       iorq_n;
   logic       rd_n;
   logic       wr_n;
   logic       core_wait_n;
   logic [7:0] di_reg;
   logic [3:0] wcnt;

   modport master (
      output cen, mcycle, tstate, intcycle_n, iorq, no_read, write, rfsh_n, ext_wait_n, di,
      input  mreq_n, iorq_n, rd_n, wr_n, core_wait_n, di_reg, wcnt
   );

   modport slave (
      input  cen, mcycle, tstate, intcycle_n, iorq, no_read, write, rfsh_n, ext_wait_n, di,
      output mreq_n, iorq_n, rd_n, wr_n, core_wait_n, di_reg, wcnt
   );
endinterface

// File: rtl/tv80_bus_seq.sv
// Negative-edge bus-strobe sequencer for the TV80 core.
// Turns the core's one-hot machine-cycle / T-state vectors into external
// mreq_n/iorq_n/rd_n/wr_n strobes (updated on negedge clk), inserts a
// per-cycle-type number of automatic wait states, drives refresh mreq_n in
// M1 T3/T4 and latches read data at the end of T3.
// Ports:
//   clk     : strobes on negedge; wait counter and data latch on posedge
//   reset_n : asynchronous active-low reset
//   bus     : tv80_bus_seq_if.slave (qualifiers in, strobes/wait/data out)
module tv80_bus_seq #(
   parameter int unsigned T2WRITE   = 0,
   parameter int unsigned M1_WAIT   = 0,
   parameter int unsigned INTA_WAIT = 2,
   parameter int unsigned MEM_WAIT  = 0,
   parameter int unsigned IO_WAIT   = 1,
   parameter int unsigned RFSH_MREQ = 1
) (
   input logic           clk,
   input logic           reset_n,
   tv80_bus_seq_if.slave bus
);

   // Wait counts wider than the 4-bit counter are truncated.
   localparam logic [3:0] M1_W   = 4'(M1_WAIT);
   localparam logic [3:0] INTA_W = 4'(INTA_WAIT);
   localparam logic [3:0] MEM_W  = 4'(MEM_WAIT);
   localparam logic [3:0] IO_W   = 4'(IO_WAIT);
   localparam bit         WR_T2  = (T2WRITE != 0);
   localparam bit         RFSH_EN = (RFSH_MREQ != 0);

   logic       mreq_d, iorq_d, rd_d, wr_d;
   logic       mreq_q, iorq_q, rd_q, wr_q;
   logic [3:0] wcnt_d, wcnt_q;
   logic [7:0] di_d, di_q;
   logic       t2_or_t3;
   logic       wr_window;
   logic       core_wait_n;

   assign t2_or_t3  = bus.tstate[1] | bus.tstate[2];
   assign wr_window = WR_T2 ? t2_or_t3 : bus.tstate[2];

   // Strobe next state; everything inactive unless a cycle phase claims it.
   always_comb begin
      mreq_d = 1'b1;
      iorq_d = 1'b1;
      rd_d   = 1'b1;
      wr_d   = 1'b1;
      if (bus.mcycle[0]) begin
         if (RFSH_EN && !bus.rfsh_n && (bus.tstate[2] | bus.tstate[3])) begin
            mreq_d = 1'b0;
         end else if (bus.rfsh_n && t2_or_t3) begin
            // Opcode fetch reads memory; interrupt acknowledge uses iorq_n alone.
            rd_d   = ~bus.intcycle_n;
            mreq_d = ~bus.intcycle_n;
            iorq_d = bus.intcycle_n;
         end
      end else if (bus.write) begin
         if (wr_window) begin
            wr_d   = 1'b0;
            iorq_d = ~bus.iorq;
            mreq_d = bus.iorq;
         end
      end else if (!bus.no_read && t2_or_t3) begin
         rd_d   = 1'b0;
         iorq_d = ~bus.iorq;
         mreq_d = bus.iorq;
      end
   end

   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mreq_q <= 1'b1;
         iorq_q <= 1'b1;
         rd_q   <= 1'b1;
         wr_q   <= 1'b1;
      end else begin
         mreq_q <= mreq_d;
         iorq_q <= iorq_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
      end
   end

   // Auto-wait counter: loaded in T1 (also on an aborted cycle), counted down in T2.
   always_comb begin
      wcnt_d = wcnt_q;
      if (bus.cen) begin
         if (bus.tstate[0]) begin
            if (bus.mcycle[0] && !bus.intcycle_n) begin
               wcnt_d = INTA_W;
            end else if (bus.mcycle[0]) begin
               wcnt_d = M1_W;
            end else if (bus.iorq) begin
               wcnt_d = IO_W;
            end else begin
               wcnt_d = MEM_W;
            end
         end else if (bus.tstate[1] && (wcnt_q != 4'd0)) begin
            wcnt_d = wcnt_q - 4'd1;
         end
      end
   end

   assign core_wait_n = bus.ext_wait_n & (wcnt_q == 4'd0);

   // Capture read data on the last T3 edge, i.e. once no wait is pending.
   always_comb begin
      di_d = di_q;
      if (bus.cen && bus.tstate[2] && core_wait_n) begin
         di_d = bus.di;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wcnt_q <= 4'd0;
         di_q   <= 8'h00;
      end else begin
         wcnt_q <= wcnt_d;
         di_q   <= di_d;
      end
   end

   assign bus.mreq_n      = mreq_q;
   assign bus.iorq_n      = iorq_q;
   assign bus.rd_n        = rd_q;
   assign bus.wr_n        = wr_q;
   assign bus.core_wait_n = core_wait_n;
   assign bus.di_reg      = di_q;
   assign bus.wcnt        = wcnt_q;

endmodule
